// File: rtl/regbank_sched.sv
// Access scheduler for a small register bank: serialized two-operand reads over valid/ready,
// plus a shared write port arbitrated between mem and alu write-back (optional ROUND_ROBIN_EN).
module regbank_sched #(
   parameter int DATA_W = 8,
   parameter int REG_AW = 2
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              op_valid,
   output logic              op_ready,
   input  logic [REG_AW-1:0] op_ra,
   input  logic [REG_AW-1:0] op_rb,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [DATA_W-1:0] res_a,
   output logic [DATA_W-1:0] res_b,
   input  logic              alu_wb_valid,
   output logic              alu_wb_ready,
   input  logic [REG_AW-1:0] alu_wb_rd,
   input  logic [DATA_W-1:0] alu_wb_data,
   input  logic              mem_wb_valid,
   output logic              mem_wb_ready,
   input  logic [REG_AW-1:0] mem_wb_rd,
   input  logic [DATA_W-1:0] mem_wb_data,
   output logic              rb_wr,
   output logic [REG_AW-1:0] rb_rd,
   output logic [DATA_W-1:0] rb_data,
   output logic [REG_AW-1:0] rb_rs,
   input  logic [DATA_W-1:0] rb_regval
);

   typedef enum logic [1:0] {IDLE, RD_A, RD_B, DONE} state_t;

   state_t            r_state;
   state_t            w_nextState;
   logic [REG_AW-1:0] r_opRb;
   logic [REG_AW-1:0] r_rs;
   logic [DATA_W-1:0] r_resA;
   logic [DATA_W-1:0] r_resB;
   logic              r_resValid;
   logic              r_wbWr;
   logic [REG_AW-1:0] r_wbRd;
   logic [DATA_W-1:0] r_wbData;
   logic              w_grantMem;
   logic              w_grantAlu;
   logic [DATA_W-1:0] w_readVal;

   assign res_a        = r_resA;
   assign res_b        = r_resB;
   assign res_valid    = r_resValid;
   assign rb_rs        = r_rs;
   assign rb_wr        = r_wbWr;
   assign rb_rd        = r_wbRd;
   assign rb_data      = r_wbData;
   assign mem_wb_ready = w_grantMem;
   assign alu_wb_ready = w_grantAlu;

   // A write issued this cycle commits at the same edge we sample, so the bank value is stale.
   assign w_readVal = (r_wbWr && (r_wbRd == r_rs)) ? r_wbData : rb_regval;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) r_state <= IDLE;
      else          r_state <= w_nextState;
   end

   always_comb begin
      w_nextState = r_state;
      op_ready    = 1'b0;
      case (r_state)
         IDLE: begin
            op_ready = 1'b1;
            if (op_valid) w_nextState = RD_A;
         end
         RD_A: w_nextState = RD_B;
         RD_B: w_nextState = DONE;
         DONE: if (res_ready) w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_opRb     <= '0;
         r_rs       <= '0;
         r_resA     <= '0;
         r_resB     <= '0;
         r_resValid <= 1'b0;
      end else begin
         case (r_state)
            IDLE: if (op_valid) begin
               r_opRb <= op_rb;
               r_rs   <= op_ra;
            end
            RD_A: begin
               r_resA <= w_readVal;
               r_rs   <= r_opRb;
            end
            RD_B: begin
               r_resB     <= w_readVal;
               r_resValid <= 1'b1;
            end
            DONE: if (res_ready) r_resValid <= 1'b0;
            default: r_resValid <= 1'b0;
         endcase
      end
   end

`ifdef ROUND_ROBIN_EN
   // Pointer names the preferred source (0 = mem, 1 = alu); it flips to the other after each grant.
   logic r_rrPtr;

   assign w_grantAlu = alu_wb_valid & (~mem_wb_valid | r_rrPtr);
   assign w_grantMem = mem_wb_valid & ~w_grantAlu;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)        r_rrPtr <= 1'b0;
      else if (w_grantMem) r_rrPtr <= 1'b1;
      else if (w_grantAlu) r_rrPtr <= 1'b0;
   end
`else
   assign w_grantMem = mem_wb_valid;
   assign w_grantAlu = alu_wb_valid & ~mem_wb_valid;
`endif

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_wbWr   <= 1'b0;
         r_wbRd   <= '0;
         r_wbData <= '0;
      end else begin
         r_wbWr <= w_grantMem | w_grantAlu;
         if (w_grantMem) begin
            r_wbRd   <= mem_wb_rd;
            r_wbData <= mem_wb_data;
         end else if (w_grantAlu) begin
            r_wbRd   <= alu_wb_rd;
            r_wbData <= alu_wb_data;
         end
      end
   end

endmodule

// File: tb/tb_regbank_sched.sv
// Scoreboard testbench for regbank_sched: directed stimulus with expected reads/writes queued,
// monitors compare bank writes and operand results; includes a behavioural register bank.
module tb_regbank_sched;

   logic       clock = 1'b0;
   logic       reset_n;
   logic       op_valid, op_ready;
   logic [1:0] op_ra, op_rb;
   logic       res_valid, res_ready;
   logic [7:0] res_a, res_b;
   logic       alu_wb_valid, alu_wb_ready;
   logic [1:0] alu_wb_rd;
   logic [7:0] alu_wb_data;
   logic       mem_wb_valid, mem_wb_ready;
   logic [1:0] mem_wb_rd;
   logic [7:0] mem_wb_data;
   logic       rb_wr;
   logic [1:0] rb_rd, rb_rs;
   logic [7:0] rb_data;
   logic [7:0] rb_regval;

   logic [7:0]  bank [4];
   logic [15:0] rdQ [$];
   logic [9:0]  wrQ [$];
   int          checks = 0;
   int          errors = 0;

   regbank_sched #(.DATA_W(8), .REG_AW(2)) dut (
      .clock(clock), .reset_n(reset_n),
      .op_valid(op_valid), .op_ready(op_ready), .op_ra(op_ra), .op_rb(op_rb),
      .res_valid(res_valid), .res_ready(res_ready), .res_a(res_a), .res_b(res_b),
      .alu_wb_valid(alu_wb_valid), .alu_wb_ready(alu_wb_ready),
      .alu_wb_rd(alu_wb_rd), .alu_wb_data(alu_wb_data),
      .mem_wb_valid(mem_wb_valid), .mem_wb_ready(mem_wb_ready),
      .mem_wb_rd(mem_wb_rd), .mem_wb_data(mem_wb_data),
      .rb_wr(rb_wr), .rb_rd(rb_rd), .rb_data(rb_data), .rb_rs(rb_rs), .rb_regval(rb_regval)
   );

   always #5 clock = ~clock;

   // Bank model: write at posedge, read data refreshed at negedge.
   always @(posedge clock) if (rb_wr) bank[rb_rd] <= rb_data;
   always @(negedge clock) rb_regval <= bank[rb_rs];

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin : wrMonitor
      logic [9:0] exp;
      forever begin
         @(negedge clock);
         if (reset_n && rb_wr) begin
            if (wrQ.size() == 0) checkOutput("unexpectedWrite", {rb_rd, rb_data}, 10'h0);
            else begin
               exp = wrQ.pop_front();
               checkOutput("wrAddr", rb_rd, exp[9:8]);
               checkOutput("wrData", rb_data, exp[7:0]);
            end
         end
      end
   end

   initial begin : rdMonitor
      logic [15:0] exp;
      forever begin
         @(negedge clock);
         if (reset_n && res_valid && res_ready) begin
            if (rdQ.size() == 0) checkOutput("unexpectedResult", {res_a, res_b}, 16'h0);
            else begin
               exp = rdQ.pop_front();
               checkOutput("resA", res_a, exp[15:8]);
               checkOutput("resB", res_b, exp[7:0]);
            end
         end
      end
   end

   task automatic aluWrite(input logic [1:0] rd, input logic [7:0] d);
      alu_wb_valid = 1'b1; alu_wb_rd = rd; alu_wb_data = d;
      #1;
      for (int n = 0; n < 8 && !alu_wb_ready; n++) tick();
      if (!alu_wb_ready) checkOutput("aluGrantTimeout", 0, 1);
      wrQ.push_back({rd, d});
      tick();
      alu_wb_valid = 1'b0;
   endtask

   task automatic waitIdle();
      for (int n = 0; n < 20 && !op_ready; n++) tick();
      if (!op_ready) checkOutput("idleTimeout", 0, 1);
   endtask

   task automatic issueOp(input logic [1:0] ra, input logic [1:0] rb,
                          input logic [7:0] ea, input logic [7:0] eb);
      waitIdle();
      op_valid = 1'b1; op_ra = ra; op_rb = rb;
      rdQ.push_back({ea, eb});
      tick();
      op_valid = 1'b0;
   endtask

   task automatic applyStimulus();
      int  lat;
      logic expMem;

      // Reset state
      reset_n = 1'b0; op_valid = 0; op_ra = 0; op_rb = 0; res_ready = 0;
      alu_wb_valid = 0; alu_wb_rd = 0; alu_wb_data = 0;
      mem_wb_valid = 0; mem_wb_rd = 0; mem_wb_data = 0;
      for (int i = 0; i < 4; i++) bank[i] = 8'h00;
      tick(); tick();
      checkOutput("rstResValid", res_valid, 0);
      checkOutput("rstRbWr", rb_wr, 0);
      checkOutput("rstRbRs", rb_rs, 0);
      checkOutput("rstResA", res_a, 0);
      checkOutput("rstOpReady", op_ready, 1);
      reset_n = 1'b1;
      tick();

      // Basic read with consumer stalled
      aluWrite(2'd1, 8'h3C);
      aluWrite(2'd3, 8'hA5);
      issueOp(2'd1, 2'd3, 8'h3C, 8'hA5);
      lat = 1;
      for (int n = 0; n < 10 && !res_valid; n++) begin tick(); lat++; end
      checkOutput("readLatency", lat, 3);
      for (int i = 0; i < 5; i++) begin
         checkOutput("holdValid", res_valid, 1);
         checkOutput("holdResA", res_a, 8'h3C);
         checkOutput("holdResB", res_b, 8'hA5);
         checkOutput("holdOpReady", op_ready, 0);
         tick();
      end
      res_ready = 1'b1;
      tick();
      checkOutput("validDropped", res_valid, 0);
      checkOutput("opReadyAgain", op_ready, 1);

      // Fixed-priority arbitration: mem wins, alu follows
      alu_wb_valid = 1; alu_wb_rd = 2'd0; alu_wb_data = 8'h11;
      mem_wb_valid = 1; mem_wb_rd = 2'd0; mem_wb_data = 8'h22;
      #1;
      checkOutput("arbMemReady", mem_wb_ready, 1);
      checkOutput("arbAluReady", alu_wb_ready, 0);
      wrQ.push_back({2'd0, 8'h22});
      tick();
      mem_wb_valid = 0;
      #1;
      checkOutput("arbAluLater", alu_wb_ready, 1);
      wrQ.push_back({2'd0, 8'h11});
      tick();
      alu_wb_valid = 0;
      issueOp(2'd0, 2'd0, 8'h11, 8'h11);
      waitIdle();

      // Sustained contention
      mem_wb_valid = 1; mem_wb_rd = 2'd1; mem_wb_data = 8'h44;
      alu_wb_valid = 1; alu_wb_rd = 2'd2; alu_wb_data = 8'h99;
      for (int i = 0; i < 4; i++) begin
`ifdef ROUND_ROBIN_EN
         expMem = (i % 2 == 0);
`else
         expMem = 1'b1;
`endif
         #1;
         checkOutput("contMemReady", mem_wb_ready, expMem);
         checkOutput("contAluReady", alu_wb_ready, !expMem);
         if (expMem) wrQ.push_back({2'd1, 8'h44});
         else        wrQ.push_back({2'd2, 8'h99});
         tick();
      end
      mem_wb_valid = 0; alu_wb_valid = 0;
      aluWrite(2'd2, 8'h99);

      // Same register on both operands
      issueOp(2'd2, 2'd2, 8'h99, 8'h99);
      waitIdle();

      // Write-back bypass during RD_A
      aluWrite(2'd0, 8'h05);
      waitIdle();
      mem_wb_valid = 1; mem_wb_rd = 2'd0; mem_wb_data = 8'h7E;
      op_valid = 1; op_ra = 2'd0; op_rb = 2'd1;
      #1;
      checkOutput("bypMemReady", mem_wb_ready, 1);
      checkOutput("bypOpReady", op_ready, 1);
      wrQ.push_back({2'd0, 8'h7E});
      rdQ.push_back({8'h7E, 8'h44});
      tick();
      mem_wb_valid = 0; op_valid = 0;
      checkOutput("bypWrInRdA", rb_wr, 1);
      checkOutput("bypRs", rb_rs, 2'd0);
      waitIdle();

      // Reset during RD_B with a write in flight
      op_valid = 1; op_ra = 2'd3; op_rb = 2'd3;
      tick();
      op_valid = 0;
      alu_wb_valid = 1; alu_wb_rd = 2'd3; alu_wb_data = 8'hEE;
      tick();
      alu_wb_valid = 0;
      checkOutput("preRstWr", rb_wr, 1);
      reset_n = 1'b0;
      #1;
      checkOutput("midRstValid", res_valid, 0);
      checkOutput("midRstWr", rb_wr, 0);
      checkOutput("midRstRs", rb_rs, 0);
      tick(); tick();
      reset_n = 1'b1;
      #1;
      checkOutput("postRstOpReady", op_ready, 1);
      tick();
      issueOp(2'd3, 2'd3, 8'hA5, 8'hA5);
      waitIdle();
      tick(); tick();
      checkOutput("rdQDrained", rdQ.size(), 0);
      checkOutput("wrQDrained", wrQ.size(), 0);
   endtask

   initial begin
      applyStimulus();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] timeout");
   end

endmodule
